// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADJ_THRESH  = 4'd5;
    localparam logic [3:0]  ADJ_ADD     = 4'd3;
    localparam int unsigned SAT_LIMIT   = 99;

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// rtl/bcd_seq_ctrl_if.sv - input/output handshake bundle of the BCD converter
interface bcd_seq_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  sat;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, busy, sat
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, busy, sat
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction for one BCD digit ahead of the shift
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= ADJ_THRESH) ? i_digit + ADJ_ADD : i_digit;
endmodule

// File: rtl/bcd_seq_ctrl.sv
// rtl/bcd_seq_ctrl.sv - iterative double-dabble converter, one bit per clock
// Optional clamp of results above 99 to 0x099 when BCD_SAT99_EN is defined.
module bcd_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_seq_ctrl_if.slave bus
);
    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_adj;
    logic               w_accept;
    logic               w_last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_CONV;
                end
            end
            S_CONV: begin
                bus.busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Adjust the current digits, then shift the next operand bit into digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(WIDTH);
            r_shift <= bus.bin;
            r_acc   <= '0;
        end else if (r_state == S_CONV) begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_shift <= r_shift << 1;
            r_acc   <= {w_adj[ACC_W-2:0], r_shift[WIDTH-1]};
        end
    end

`ifdef BCD_SAT99_EN
    localparam logic [ACC_W+7:0] SAT_WIDE = (ACC_W + 8)'(8'h99);
    localparam logic [ACC_W-1:0] SAT_BCD  = SAT_WIDE[ACC_W-1:0];

    logic r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_sat <= 1'b0;
        else if (w_accept) r_sat <= (32'(bus.bin) > 32'(SAT_LIMIT));
    end

    assign bus.bcd = ((r_state == S_DONE) && r_sat) ? SAT_BCD : r_acc;
    assign bus.sat = r_sat;
`else
    assign bus.bcd = r_acc;
    assign bus.sat = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb/tb_bcd_seq_ctrl.sv - randomized self-checking bench for bcd_seq_ctrl (honours BCD_SAT99_EN)
module tb_bcd_seq_ctrl;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BOUND  = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bcd_seq_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_seq_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int x;
`ifdef BCD_SAT99_EN
        if (v > 99) return 12'h099;
`endif
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_sat(input int v);
`ifdef BCD_SAT99_EN
        return v > 99;
`else
        return (v < 0);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present v for one cycle from IDLE; returns the cycle count after the accept edge.
    task automatic send(input int v, output int acc_cyc);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready: got %b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.bin      = 8'(v);
        step();
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.bin      = 8'($urandom);
    endtask

    // Wait for out_valid, checking CONV-phase flags; returns cycles since accept.
    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < BOUND) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL conv_flags: in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy);
            end
            step();
            lat++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout: no out_valid after %0d cycles", lat);
        end
    endtask

    task automatic check_result(input string name, input int v, input int lat);
        checks++;
        if (bus.bcd !== ref_bcd(v) || bus.sat !== ref_sat(v)) begin
            errors++;
            $display("FAIL %s: bin=%0d bcd=%h sat=%b want bcd=%h sat=%b",
                     name, v, bus.bcd, bus.sat, ref_bcd(v), ref_sat(v));
        end
        checks++;
        if (lat !== WIDTH) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, WIDTH);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.bcd !== 12'h000 || bus.sat !== 1'b0) begin
            errors++;
            $display("FAIL %s: in_ready=%b out_valid=%b busy=%b bcd=%h sat=%b want 1/0/0/000/0",
                     name, bus.in_ready, bus.out_valid, bus.busy, bus.bcd, bus.sat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();
        check_reset_vals("post_reset_idle");
    endtask

    task automatic test_zero();
        int a, lat;
        send(0, a);
        wait_result(lat);
        check_result("zero", 0, lat);
        drain();
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{9, 10, 99};
        int acc[3];
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(vals[i], acc[i]);
            wait_result(lat);
            check_result("b2b", vals[i], lat);
            step();
        end
        bus.out_ready = 1'b0;
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc[i] - acc[i-1] !== WIDTH + 2) begin
                errors++;
                $display("FAIL b2b_period: got %0d want %0d", acc[i] - acc[i-1], WIDTH + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int a, lat;
        logic [11:0] held;
        send(255, a);
        wait_result(lat);
        check_result("bp", 255, lat);
        held = bus.bcd;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.bcd !== held) begin
                errors++;
                $display("FAIL bp_hold: out_valid=%b bcd=%h want 1/%h", bus.out_valid, bus.bcd, held);
            end
        end
        drain();
    endtask

    task automatic test_ignore_in_valid();
        int a, lat;
        send(123, a);
        step();
        bus.in_valid = 1'b1;
        bus.bin      = 8'd77;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        wait_result(lat);
        check_result("ignore", 123, lat + 2);
        drain();
    endtask

    task automatic test_reset_mid_conv();
        int a, lat;
        send(200, a);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_conv");
        step();
        rst_n = 1'b1;
        step();
        send(42, a);
        wait_result(lat);
        check_result("after_reset", 42, lat);
        drain();
    endtask

    task automatic test_sat_pair();
        int a, lat;
        send(200, a);
        wait_result(lat);
        check_result("sat_200", 200, lat);
        drain();
        send(50, a);
        wait_result(lat);
        check_result("sat_50", 50, lat);
        drain();
    endtask

    task automatic test_random();
        int a, lat, v, hold;
        for (int n = 0; n < 25; n++) begin
            v = int'($urandom_range(0, 255));
            send(v, a);
            wait_result(lat);
            check_result("random", v, lat);
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) step();
            checks++;
            if (bus.bcd !== ref_bcd(v) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL random_hold: bcd=%h out_valid=%b want %h/1", bus.bcd, bus.out_valid, ref_bcd(v));
            end
            drain();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.bin       = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_conv();
        test_sat_pair();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/bcd_seq_ctrl.md
Name: bcd_seq_ctrl

Overview:
Sequential binary-to-BCD converter controller. Runs the shift/add-3 (double-dabble) algorithm one bit per clock under an FSM, with valid/ready handshakes on input and output. It sits between the adder result and the 7-segment display driver. It replaces a fully unrolled combinational converter with a small, timing-friendly iterative datapath whose latency is fixed and known.

Parameters:
WIDTH, 8, binary input width in bits (WIDTH >= 1).
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  bin is valid this cycle.
in_ready  output  1  block accepts a new value (IDLE only).
bin  input  WIDTH  unsigned binary operand.
out_valid  output  1  bcd holds a completed result.
out_ready  input  1  consumer accepts the result.
bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
busy  output  1  conversion in progress (CONV state).
sat  output  1  result was clamped (see Optional Feature); tied 0 when the feature is off.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, bcd=0, sat=0, bit counter=0, internal shift register=0.
- IDLE: in_ready=1. On in_valid&in_ready, capture bin into shift register, clear the BCD accumulator, load counter=WIDTH, go to CONV. Otherwise stay in IDLE.
- CONV: in_ready=0, busy=1. Each cycle:
  - add 3 to every accumulator digit whose value is >=5;
  - shift {accumulator, shift register} left by 1, moving the MSB of the shift register into bit 0 of digit 0;
  - decrement the counter.
  - When the counter reaches 1 at the start of a cycle, perform that final iteration and go to DONE.
  - Adjust-before-shift order is mandatory. The final iteration has no trailing adjust.
- DONE: out_valid=1 and bcd is stable. The accumulator is not modified while out_valid=1. On out_ready, go to IDLE next cycle.
- Latency: input accepted at edge N; out_valid rises after edge N+WIDTH (8 cycles for the default width).
- Throughput: one conversion per WIDTH+2 cycles minimum; no overlap of input and output phases.
- Back-pressure: out_valid stays high and bcd stays constant for any number of cycles while out_ready=0.
- in_valid outside IDLE is ignored. bin is not required to stay stable after the accept edge.
- out_ready asserted in IDLE or CONV has no effect.
- bin=0 produces bcd=0 after the full WIDTH cycles; there is no early exit.
- Reset mid-CONV or mid-DONE: immediate return to the reset values; the partial result is discarded.
- Every digit of the result is <=9. All arithmetic is unsigned and there is no carry out of the top digit (guaranteed by the DIGITS constraint).

Optional Feature:
Macro BCD_SAT99_EN.
- Defined: at the accept edge, register sat = (bin > 99). In DONE, when sat=1, bcd reads 0x099 (ones=9, tens=9, upper digits 0) and the sat port is high. When sat=0, behaviour is as without the macro. sat clears on reset and on the next accept.
- Not defined: the comparator is not built, the sat port is constant 0, and bcd always carries the exact conversion.

Decomposition:
- Package bcd_pkg:
  - state encoding (IDLE=2'd0, CONV=2'd1, DONE=2'd2);
  - BCD_DIGIT_W=4;
  - ADJ_THRESH=4'd5;
  - ADJ_ADD=4'd3;
  - SAT_LIMIT=99.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, adds 3 when the input is >=5. Instantiate DIGITS copies with a generate loop.
- The FSM, counter and shift registers live in bcd_seq_ctrl.

Test Plan:
- Reset then bin=8'd0 accepted -> out_valid exactly 8 cycles later, bcd=12'h000, sat=0.
- bin=9, then 10, then 99 back-to-back (out_ready=1) -> bcd 12'h009, 12'h010, 12'h099; in_ready low during each CONV; one conversion every 10 cycles.
- bin=255, out_ready held 0 for 5 cycles -> bcd=12'h255 stays stable and out_valid stays 1; returns to IDLE the cycle after out_ready=1.
- in_valid pulsed with bin=77 during CONV of bin=123 -> ignored; result 12'h123.
- rst_n asserted at cycle 4 of CONV for bin=200 -> outputs reset immediately; a following bin=42 yields 12'h042.
- With BCD_SAT99_EN: bin=200 -> bcd=12'h099, sat=1; bin=50 -> bcd=12'h050, sat=0.
